// File: rtl/shift_pkg.sv
// shift_pkg: op encodings, in-flight beat record and the
// helpers that split mux levels across pipeline stages.
package shift_pkg;

  localparam int MAX_W = 128;
  localparam int MAX_L = 7;

  typedef enum logic [2:0] {
    OP_SLL = 3'd0,
    OP_SRL = 3'd1,
    OP_SRA = 3'd2,
    OP_ROL = 3'd3,
    OP_ROR = 3'd4
  } op_e;

  // data is sized for the widest build; narrower builds
  // use the low WIDTH bits only.
  typedef struct packed {
    logic             valid;
    logic [MAX_W-1:0] data;
    op_e              op;
    logic             fill;
    logic             half;
    logic [MAX_L-1:0] amt;
    logic [3:0]       tag;
    logic             err;
  } beat_t;

  // Levels owned by stage k; leftovers go to early stages.
  function automatic int lvl_num(int lvls, int stages,
                                 int k);
    return lvls / stages +
           ((k < lvls % stages) ? 1 : 0);
  endfunction

  function automatic int lvl_first(int lvls, int stages,
                                   int k);
    return k * (lvls / stages) +
           ((k < lvls % stages) ? k : lvls % stages);
  endfunction

endpackage

// File: rtl/shift_pipe_if.sv
// shift_pipe_if: operand/result handshake bundle.
// master drives in_* and out_ready; slave is the shifter.
interface shift_pipe_if #(
  parameter int WIDTH = 64,
  parameter int AMT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic             in_half;
  logic [AMT_W-1:0] in_amt;
  logic [WIDTH-1:0] in_data;
  logic [3:0]       in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [3:0]       out_tag;
  logic             out_err;

  modport master (
    output in_valid, in_op, in_half, in_amt,
    output in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data,
    input  out_tag, out_err
  );

  modport slave (
    input  in_valid, in_op, in_half, in_amt,
    input  in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data,
    output out_tag, out_err
  );
endinterface

// File: rtl/shift_pipe_stage.sv
// shift_pipe_stage: one register stage applying levels
// FIRST_LVL..FIRST_LVL+NUM_LVL-1 of the left-shift network.
// Ports: clk, rst, d (beat in), over (amount >= WIDTH, first
// stage only), adv_nxt (downstream advance), adv, q (beat out).
module shift_pipe_stage
  import shift_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int LVLS      = 6,
  parameter int FIRST_LVL = 0,
  parameter int NUM_LVL   = 3
) (
  input  logic  clk,
  input  logic  rst,
  input  beat_t d,
  input  logic  over,
  input  logic  adv_nxt,
  output logic  adv,
  output beat_t q
);

  localparam int H = WIDTH / 2;
  localparam bit IS_FIRST = (FIRST_LVL == 0);
  localparam bit IS_LAST = (FIRST_LVL + NUM_LVL == LVLS);

  // Bit reverse over the active width (H bits in half mode).
  function automatic logic [WIDTH-1:0] rev(
    logic [WIDTH-1:0] x, logic half);
    logic [WIDTH-1:0] r;
    for (int j = 0; j < WIDTH; j++) r[j] = x[WIDTH-1-j];
    if (half) begin
      r = '0;
      for (int j = 0; j < H; j++) r[j] = x[H-1-j];
    end
    return r;
  endfunction

  // One left level; vacated low bits take the wrapped bits
  // for rotates, else the fill bit.
  function automatic logic [WIDTH-1:0] shl(
    logic [WIDTH-1:0] x, int s, logic rot,
    logic fill, logic half);
    logic [WIDTH-1:0] ins;
    logic [H-1:0] lo, lo_ins;
    ins = rot ? x >> (WIDTH - s) :
          (fill ? ~({WIDTH{1'b1}} << s) : '0);
    lo = x[H-1:0];
    lo_ins = rot ? lo >> (H - s) :
             (fill ? ~({H{1'b1}} << s) : '0);
    return half ? {{H{1'b0}}, (lo << s) | lo_ins}
                : (x << s) | ins;
  endfunction

  beat_t b;
  logic [WIDTH-1:0] w;
  logic right, rot;

  always_comb begin
    b = d;
    w = d.data[WIDTH-1:0];
    right = d.op inside {OP_SRL, OP_SRA, OP_ROR};
    rot = d.op inside {OP_ROL, OP_ROR};
    if (IS_FIRST) begin
      b.err = d.op > OP_ROR;
      b.fill = (d.op == OP_SRA) &&
               (d.half ? w[H-1] : w[WIDTH-1]);
      // half mode never uses the top level
      if (d.half) b.amt[LVLS-1] = 1'b0;
      if (right) w = rev(w, d.half);
    end
    if (over && !rot && !b.half) w = {WIDTH{b.fill}};
    for (int k = 0; k < NUM_LVL; k++) begin
      if (b.amt[FIRST_LVL+k])
        w = shl(w, 1 << (FIRST_LVL + k), rot,
                b.fill, b.half);
    end
    if (IS_LAST) begin
      if (right) w = rev(w, b.half);
      if (b.half) w = {{H{w[H-1]}}, w[H-1:0]};
      if (b.err) w = '0;
    end
    b.data = '0;
    b.data[WIDTH-1:0] = w;
  end

  assign adv = !q.valid || adv_nxt;

  // Bubbles only clear valid so held data stays put.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (adv) begin
      if (d.valid) q <= b;
      else q.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// shift_pipe: pipelined shifter/rotator with valid/ready.
// Ports: clk, rst (sync, active-high), bus (shift_pipe_if.slave).
module shift_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2,
  parameter int AMT_W  = 8
) (
  input logic        clk,
  input logic        rst,
  shift_pipe_if.slave bus
);

  localparam int LVLS = $clog2(WIDTH);

  beat_t raw;
  beat_t st [STAGES];
  logic [STAGES:0] adv;
  logic over;

  always_comb begin
    raw = '0;
    raw.valid = bus.in_valid;
    raw.data[WIDTH-1:0] = bus.in_data;
    raw.op = op_e'(bus.in_op);
    raw.half = bus.in_half;
    raw.amt[LVLS-1:0] = bus.in_amt[LVLS-1:0];
    raw.tag = bus.in_tag;
  end

  assign over = |bus.in_amt[AMT_W-1:LVLS];
  assign adv[STAGES] = bus.out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    beat_t d_in;
    logic ov;
    if (k == 0) begin : g_first
      assign d_in = raw;
      assign ov = over;
    end else begin : g_rest
      assign d_in = st[k-1];
      assign ov = 1'b0;
    end
    shift_pipe_stage #(
      .WIDTH(WIDTH),
      .LVLS(LVLS),
      .FIRST_LVL(lvl_first(LVLS, STAGES, k)),
      .NUM_LVL(lvl_num(LVLS, STAGES, k))
    ) u_stage (
      .clk(clk),
      .rst(rst),
      .d(d_in),
      .over(ov),
      .adv_nxt(adv[k+1]),
      .adv(adv[k]),
      .q(st[k])
    );
  end

  assign bus.in_ready = adv[0];
  assign bus.out_valid = st[STAGES-1].valid;
  assign bus.out_data = st[STAGES-1].data[WIDTH-1:0];
  assign bus.out_tag = st[STAGES-1].tag;
  assign bus.out_err = st[STAGES-1].err;

endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: checks shift_pipe at 64/2, 32/1 and 32/5
// against an arithmetic reference model and a result queue.
module tb_shift_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid_v  [3];
  logic [2:0]  in_op_v     [3];
  logic        in_half_v   [3];
  logic [7:0]  in_amt_v    [3];
  logic [63:0] in_data_v   [3];
  logic [3:0]  in_tag_v    [3];
  logic        out_ready_v [3];
  logic        in_ready_w  [3];
  logic        out_valid_w [3];
  logic [63:0] out_data_w  [3];
  logic [3:0]  out_tag_w   [3];
  logic        out_err_w   [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 0) ? 64 : 32;
    localparam int S = (g == 0) ? 2 : ((g == 1) ? 1 : 5);
    shift_pipe_if #(.WIDTH(W), .AMT_W(8)) bus ();
    shift_pipe #(.WIDTH(W), .STAGES(S), .AMT_W(8)) dut (
      .clk(clk), .rst(rst), .bus(bus));
    assign bus.in_valid = in_valid_v[g];
    assign bus.in_op = in_op_v[g];
    assign bus.in_half = in_half_v[g];
    assign bus.in_amt = in_amt_v[g];
    assign bus.in_data = in_data_v[g][W-1:0];
    assign bus.in_tag = in_tag_v[g];
    assign bus.out_ready = out_ready_v[g];
    assign in_ready_w[g] = bus.in_ready;
    assign out_valid_w[g] = bus.out_valid;
    assign out_data_w[g] = 64'(bus.out_data);
    assign out_tag_w[g] = bus.out_tag;
    assign out_err_w[g] = bus.out_err;
  end

  typedef struct {
    logic [3:0]  tag;
    logic        err;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t sb [$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_lat = 0;
  bit stall_p = 0;
  bit acc = 0;
  bit use_exp = 0;
  logic [63:0] exp_val;
  logic [63:0] prev_data;
  logic [3:0] prev_tag;

  function automatic int wid(input int d);
    return (d == 0) ? 64 : 32;
  endfunction

  function automatic int stg(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 5);
  endfunction

  // {err, data} from the operation definitions directly.
  function automatic logic [64:0] model(
    input int w, input logic [2:0] op, input logic half,
    input logic [7:0] amt, input logic [63:0] x);
    int n, a, k;
    logic [63:0] m, wm, v, r;
    logic sg;
    n = half ? w / 2 : w;
    a = half ? int'(amt) % n : int'(amt);
    m = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    wm = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    v = x & m;
    sg = v[n-1];
    k = a % n;
    r = '0;
    case (op)
      3'd0: r = (a >= n) ? 64'd0 : (v << a) & m;
      3'd1: r = (a >= n) ? 64'd0 : v >> a;
      3'd2: r = (a >= n) ? (sg ? m : 64'd0) :
                ((v >> a) | (sg ? (m & ~(m >> a)) : 64'd0));
      3'd3: r = (k == 0) ? v :
                (((v << k) | (v >> (n - k))) & m);
      3'd4: r = (k == 0) ? v :
                (((v >> k) | (v << (n - k))) & m);
      default: return {1'b1, 64'd0};
    endcase
    if (half && r[n-1]) r = r | ~m;
    return {1'b0, r & wm};
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             name, got, expv);
    end
  endtask

  // Sample just after the negedge, then advance one cycle.
  task automatic tick(input int d);
    exp_t e;
    logic [64:0] m;
    #1;
    acc = 1'b0;
    if (stall_p) begin
      chk("hold_valid", 64'(out_valid_w[d]), 64'd1);
      chk("hold_data", out_data_w[d], prev_data);
      chk("hold_tag", 64'(out_tag_w[d]), 64'(prev_tag));
    end
    if (out_valid_w[d] && sb.size() == 0) begin
      chk("stale_out", 64'(out_valid_w[d]), 64'd0);
    end else if (out_valid_w[d] && out_ready_v[d]) begin
      e = sb.pop_front();
      chk("data", out_data_w[d], e.data);
      chk("tag", 64'(out_tag_w[d]), 64'(e.tag));
      chk("err", 64'(out_err_w[d]), 64'(e.err));
      if (chk_lat)
        chk("latency", 64'(cyc - e.cyc), 64'(stg(d)));
    end
    stall_p = out_valid_w[d] && !out_ready_v[d];
    prev_data = out_data_w[d];
    prev_tag = out_tag_w[d];
    if (in_valid_v[d] && in_ready_w[d]) begin
      acc = 1'b1;
      m = model(wid(d), in_op_v[d], in_half_v[d],
                in_amt_v[d], in_data_v[d]);
      e.tag = in_tag_v[d];
      e.err = m[64];
      e.data = use_exp ? exp_val : m[63:0];
      e.cyc = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic set_beat(input int d, input logic [2:0] op,
                          input logic half,
                          input logic [7:0] amt,
                          input logic [63:0] data,
                          input logic [3:0] tag);
    in_valid_v[d] = 1'b1;
    in_op_v[d] = op;
    in_half_v[d] = half;
    in_amt_v[d] = amt;
    in_data_v[d] = data;
    in_tag_v[d] = tag;
  endtask

  task automatic set_rand(input int d, input logic [3:0] tag,
                          input int nops);
    logic [7:0] a;
    if ($urandom % 3 == 0)
      a = 8'($urandom_range(wid(d) + 2, wid(d) - 2));
    else
      a = 8'($urandom);
    set_beat(d, 3'($urandom % nops), 1'($urandom),
             a, {$urandom, $urandom}, tag);
  endtask

  task automatic send(input int d, input logic [2:0] op,
                      input logic half, input logic [7:0] amt,
                      input logic [63:0] data,
                      input logic [3:0] tag,
                      input bit has_exp,
                      input logic [63:0] expv);
    set_beat(d, op, half, amt, data, tag);
    use_exp = has_exp;
    exp_val = expv;
    for (int i = 0; i < 64; i++) begin
      tick(d);
      if (acc) break;
    end
    use_exp = 1'b0;
    chk("accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic drain(input int d);
    in_valid_v[d] = 1'b0;
    out_ready_v[d] = 1'b1;
    for (int i = 0; i < 64 && sb.size() != 0; i++) tick(d);
    chk("drain_empty", 64'(sb.size()), 64'd0);
    tick(d);
    tick(d);
  endtask

  task automatic do_reset(input int d);
    in_valid_v[d] = 1'b0;
    rst = 1'b1;
    sb.delete();
    stall_p = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc++;
    #1;
    chk("rst_valid", 64'(out_valid_w[d]), 64'd0);
    chk("rst_data", out_data_w[d], 64'd0);
    chk("rst_tag", 64'(out_tag_w[d]), 64'd0);
    chk("rst_err", 64'(out_err_w[d]), 64'd0);
    chk("rst_ready", 64'(in_ready_w[d]), 64'd1);
  endtask

  task automatic suite(input int d);
    logic [63:0] p;
    logic [63:0] sll_exp [5];
    int amts [5];
    int n;
    bit w64;
    w64 = (d == 0);
    p = 64'h8000_0000_0000_0001;
    amts = '{0, 1, 63, 64, 200};
    sll_exp = '{64'h8000_0000_0000_0001, 64'h2,
                64'h8000_0000_0000_0000, 64'h0, 64'h0};
    do_reset(d);

    // back-to-back stream, latency checked on every result
    out_ready_v[d] = 1'b1;
    chk_lat = 1'b1;
    for (int op = 0; op < 3; op++)
      for (int i = 0; i < 5; i++)
        send(d, 3'(op), 1'b0, 8'(amts[i]), p,
             4'(op * 5 + i),
             w64 && (op == 0 || (op == 2 && i == 3)),
             (op == 0) ? sll_exp[i] : 64'hFFFF_FFFF_FFFF_FFFF);
    send(d, 3'd3, 1'b0, 8'd68, 64'h0123_4567_89AB_CDEF,
         4'd1, w64, 64'h1234_5678_9ABC_DEF0);
    send(d, 3'd4, 1'b0, 8'd4, 64'h0123_4567_89AB_CDEF,
         4'd2, w64, 64'hF012_3456_789A_BCDE);
    send(d, 3'd1, 1'b1, 8'd0, 64'h0000_0000_8000_0000,
         4'd3, w64, 64'hFFFF_FFFF_8000_0000);
    send(d, 3'd0, 1'b1, 8'd33, 64'h1,
         4'd4, w64, 64'h2);
    send(d, 3'd2, 1'b1, 8'd31, 64'hFFFF_FFFF_8000_0000,
         4'd5, w64, 64'hFFFF_FFFF_FFFF_FFFF);
    drain(d);
    chk_lat = 1'b0;

    // backpressure: fill with tags 1..5, then random drain
    out_ready_v[d] = 1'b0;
    n = 0;
    for (int i = 0; i < stg(d) + 2; i++) begin
      if (n < 5) set_rand(d, 4'(n + 1), 5);
      else in_valid_v[d] = 1'b0;
      tick(d);
      if (acc) n++;
    end
    chk("bp_accepted", 64'(n), 64'(stg(d)));
    #1;
    chk("bp_in_ready", 64'(in_ready_w[d]), 64'd0);
    for (int i = 0; i < 300 && (n < 5 || sb.size() != 0);
         i++) begin
      out_ready_v[d] = 1'($urandom);
      if (n < 5) set_rand(d, 4'(n + 1), 5);
      else in_valid_v[d] = 1'b0;
      tick(d);
      if (acc) n++;
    end
    chk("bp_sent", 64'(n), 64'd5);
    drain(d);

    // reserved op between two valid ops
    out_ready_v[d] = 1'b1;
    send(d, 3'd0, 1'b0, 8'd4, 64'hFF, 4'd1, 1'b0, 64'd0);
    send(d, 3'd6, 1'b0, 8'd4, 64'hFF, 4'd2, 1'b0, 64'd0);
    send(d, 3'd1, 1'b0, 8'd4, 64'hFF, 4'd3, 1'b0, 64'd0);
    drain(d);

    // reset with beats in flight
    out_ready_v[d] = 1'b0;
    set_rand(d, 4'd7, 5);
    tick(d);
    set_rand(d, 4'd8, 5);
    tick(d);
    do_reset(d);
    out_ready_v[d] = 1'b1;
    for (int i = 0; i < 8; i++) tick(d);
    send(d, 3'd3, 1'b0, 8'd1, 64'h5, 4'd9, 1'b0, 64'd0);
    drain(d);

    // random traffic with random stalls
    n = 0;
    for (int i = 0; i < 400 && n < 80; i++) begin
      out_ready_v[d] = ($urandom % 4) != 0;
      if ($urandom % 4 != 0) set_rand(d, 4'(n), 8);
      else in_valid_v[d] = 1'b0;
      tick(d);
      if (acc) n++;
    end
    chk("rand_sent", 64'(n), 64'd80);
    drain(d);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      in_valid_v[i] = 1'b0;
      in_op_v[i] = '0;
      in_half_v[i] = 1'b0;
      in_amt_v[i] = '0;
      in_data_v[i] = '0;
      in_tag_v[i] = '0;
      out_ready_v[i] = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) suite(d);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
